// File: rtl/signed_bcd_converter.sv
// signed_bcd_converter
//
// Converts an 8-bit value (two's complement or unsigned, selected by SIGNED_IN) into a sign
// flag plus three BCD digits of its magnitude, using a sequential double-dabble
// (shift-and-add-3) engine: one accept cycle, eight shift cycles, one done cycle.
//
// Parameters
//   SIGNED_IN  1: A is two's complement (-128..127); 0: A is unsigned (0..255)
//
// Ports
//   clk       in   rising-edge clock, sole clock domain
//   rst_n     in   synchronous active-low reset
//   start     in   conversion request, honoured only in IDLE
//   A[7:0]    in   value to convert, captured on the edge that accepts start
//   sign      out  1 when the captured value was negative
//   hundreds  out  BCD hundreds digit of the magnitude (0..2)
//   tens      out  BCD tens digit of the magnitude (0..9)
//   ones      out  BCD ones digit of the magnitude (0..9)
//   busy      out  high for the eight shift cycles
//   done      out  single-cycle completion pulse
//
// The result registers are loaded only on entry to DONE, so they always show the last
// completed conversion and never the partial contents of the shift register.

module signed_bcd_converter #(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] A,
    output logic       sign,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [3:0] NumShifts = 4'd8;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] bcd_q, bcd_d;
    logic [7:0]  mag_q, mag_d;
    logic        neg_q, neg_d;

    logic        sign_q, sign_d;
    logic [3:0]  hundreds_q, hundreds_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;

    logic        in_neg;
    logic [7:0]  in_mag;
    logic [11:0] bcd_adj;
    logic [11:0] bcd_shift;
    logic [7:0]  mag_shift;

    // Double-dabble correction: a digit >= 5 would become >= 10 after the shift, so bias it
    // by 3 beforehand to make the carry land in the next digit.
    function automatic logic [3:0] add3(input logic [3:0] digit);
        return (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

    // -------------------------------------------------------------------------------------
    // Input sign/magnitude split. A == 0 has A[7] == 0, so zero is never negative.
    // Negating 0x80 wraps back to 0x80, which read as unsigned is the correct 128.
    // -------------------------------------------------------------------------------------
    always_comb begin
        in_neg = SIGNED_IN && A[7];
        in_mag = in_neg ? (~A + 8'd1) : A;
    end

    // -------------------------------------------------------------------------------------
    // One double-dabble step: correct every digit, then shift {bcd, magnitude} left by one.
    // -------------------------------------------------------------------------------------
    always_comb begin
        bcd_adj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        bcd_shift = {bcd_adj[10:0], mag_q[7]};
        mag_shift = {mag_q[6:0], 1'b0};
    end

    // -------------------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        mag_d      = mag_q;
        neg_d      = neg_q;
        sign_d     = sign_q;
        hundreds_d = hundreds_q;
        tens_d     = tens_q;
        ones_d     = ones_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    neg_d   = in_neg;
                    mag_d   = in_mag;
                    bcd_d   = 12'd0;
                    cnt_d   = NumShifts;
                    state_d = StShift;
                end
            end

            StShift: begin
                bcd_d = bcd_shift;
                mag_d = mag_shift;
                cnt_d = cnt_q - 4'd1;
                // Last shift: publish the finished digits straight from the shift result
                if (cnt_q == 4'd1) begin
                    state_d    = StDone;
                    sign_d     = neg_q;
                    hundreds_d = bcd_shift[11:8];
                    tens_d     = bcd_shift[7:4];
                    ones_d     = bcd_shift[3:0];
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------------------
    // State registers; reset wins over everything, including a start on the same edge.
    // -------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            bcd_q      <= 12'd0;
            mag_q      <= 8'd0;
            neg_q      <= 1'b0;
            sign_q     <= 1'b0;
            hundreds_q <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            sign_q     <= sign_d;
            hundreds_q <= hundreds_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
        end
    end

    // -------------------------------------------------------------------------------------
    // Outputs: status decoded from the registered state, so both are glitch-free per cycle.
    // -------------------------------------------------------------------------------------
    always_comb begin
        busy     = (state_q == StShift);
        done     = (state_q == StDone);
        sign     = sign_q;
        hundreds = hundreds_q;
        tens     = tens_q;
        ones     = ones_q;
    end

`ifndef SYNTHESIS
    a_digits_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (hundreds_q <= 4'd2) && (tens_q <= 4'd9) && (ones_q <= 4'd9));

    a_busy_done_exclusive: assert property (@(posedge clk) !(busy && done));
`endif

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Self-checking bench for signed_bcd_converter. A signed and an unsigned instance share the
// same stimulus; an arithmetic model predicts status and result outputs every cycle, and
// directed literal expectations pin both the model and the DUT.

module tb_signed_bcd_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] a;

    logic [1:0]      sign_w, busy_w, done_w;
    logic [1:0][3:0] h_w, t_w, o_w;

    // Instance 0: signed input; instance 1: unsigned input
    signed_bcd_converter #(.SIGNED_IN(1'b1)) u_dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (a),
        .sign     (sign_w[0]),
        .hundreds (h_w[0]),
        .tens     (t_w[0]),
        .ones     (o_w[0]),
        .busy     (busy_w[0]),
        .done     (done_w[0])
    );

    signed_bcd_converter #(.SIGNED_IN(1'b0)) u_dut_u (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (a),
        .sign     (sign_w[1]),
        .hundreds (h_w[1]),
        .tens     (t_w[1]),
        .ones     (o_w[1]),
        .busy     (busy_w[1]),
        .done     (done_w[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: ph = 0 idle, 1..8 converting (busy), 9 = done cycle
    int ph [2]     = '{0, 0};
    int e_sign [2] = '{0, 0};
    int e_h [2]    = '{0, 0};
    int e_t [2]    = '{0, 0};
    int e_o [2]    = '{0, 0};
    int p_sign [2] = '{0, 0};
    int p_h [2]    = '{0, 0};
    int p_t [2]    = '{0, 0};
    int p_o [2]    = '{0, 0};
    int dn_cnt [2] = '{0, 0};
    int dn_cyc [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void conv(input bit si, input logic [7:0] v,
                                 output int s, output int h, output int t, output int o);
        int m;
        s = (si && v[7]) ? 1 : 0;
        m = (s == 1) ? (256 - int'(v)) : int'(v);
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                ph[i]     = 0;
                e_sign[i] = 0;
                e_h[i]    = 0;
                e_t[i]    = 0;
                e_o[i]    = 0;
            end else if (ph[i] == 0) begin
                if (start) begin
                    conv(i == 0, a, p_sign[i], p_h[i], p_t[i], p_o[i]);
                    ph[i] = 1;
                end
            end else if (ph[i] < 9) begin
                ph[i]++;
                if (ph[i] == 9) begin
                    e_sign[i] = p_sign[i];
                    e_h[i]    = p_h[i];
                    e_t[i]    = p_t[i];
                    e_o[i]    = p_o[i];
                end
            end else begin
                ph[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy[%0d]", i), int'(busy_w[i]), int'(ph[i] >= 1 && ph[i] <= 8));
            chk($sformatf("done[%0d]", i), int'(done_w[i]), int'(ph[i] == 9));
            chk($sformatf("sign[%0d]", i), int'(sign_w[i]), e_sign[i]);
            chk($sformatf("hundreds[%0d]", i), int'(h_w[i]), e_h[i]);
            chk($sformatf("tens[%0d]", i), int'(t_w[i]), e_t[i]);
            chk($sformatf("ones[%0d]", i), int'(o_w[i]), e_o[i]);
            if (done_w[i] === 1'b1) dn_cnt[i]++;
        end
        if (done_w[0] === 1'b1) dn_cyc.push_back(cyc);
    end

    // Literal expectations against both the model and the DUT
    task automatic lit(input string nm, input int i, input int s, input int h, input int t,
                       input int o);
        chk({nm, "_model_sign"}, e_sign[i], s);
        chk({nm, "_model_h"}, e_h[i], h);
        chk({nm, "_model_t"}, e_t[i], t);
        chk({nm, "_model_o"}, e_o[i], o);
        chk({nm, "_dut_sign"}, int'(sign_w[i]), s);
        chk({nm, "_dut_h"}, int'(h_w[i]), h);
        chk({nm, "_dut_t"}, int'(t_w[i]), t);
        chk({nm, "_dut_o"}, int'(o_w[i]), o);
    endtask

    // Called on the negedge just after the accepting edge; returns on the done negedge
    task automatic wait_done(input string nm, output int lat, output int nb);
        lat = 0;
        nb  = 0;
        while (done_w[0] !== 1'b1 && lat < 20) begin
            if (busy_w[0] === 1'b1) nb++;
            @(negedge clk);
            lat++;
        end
        chk({nm, "_done_seen"}, int'(done_w[0] === 1'b1), 1);
    endtask

    task automatic convert(input string nm, input logic [7:0] v);
        int lat, nb;
        a     = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~v;  // must not disturb the conversion in flight
        wait_done(nm, lat, nb);
        chk({nm, "_latency"}, lat, 8);
        chk({nm, "_busy_cycles"}, nb, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n0, lat, nb;
        // Reset with start asserted on the same edges: the request must be discarded
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h85;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            lit($sformatf("reset%0d", i), i, 0, 0, 0, 0);
            chk($sformatf("reset_busy%0d", i), int'(busy_w[i]), 0);
            chk($sformatf("reset_done%0d", i), int'(done_w[i]), 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", int'(busy_w[0]), 0);

        convert("c85", 8'h85);
        lit("c85_s", 0, 1, 1, 2, 3);
        lit("c85_u", 1, 0, 1, 3, 3);
        @(negedge clk);
        convert("c80", 8'h80);
        lit("c80_s", 0, 1, 1, 2, 8);
        lit("c80_u", 1, 0, 1, 2, 8);
        @(negedge clk);
        convert("c7f", 8'h7F);
        lit("c7f_s", 0, 0, 1, 2, 7);
        lit("c7f_u", 1, 0, 1, 2, 7);
        @(negedge clk);
        convert("c00", 8'h00);
        lit("c00_s", 0, 0, 0, 0, 0);
        lit("c00_u", 1, 0, 0, 0, 0);
        @(negedge clk);
        convert("cff", 8'hFF);
        lit("cff_s", 0, 1, 0, 0, 1);
        lit("cff_u", 1, 0, 2, 5, 5);
        @(negedge clk);
        convert("c09", 8'h09);
        lit("c09_s", 0, 0, 0, 0, 9);
        lit("c09_u", 1, 0, 0, 0, 9);
        @(negedge clk);

        // Start pulse in the middle of a conversion is ignored
        d0    = dn_cnt[0];
        a     = 8'h85;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        @(negedge clk);
        @(negedge clk);
        a     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", lat, nb);
        chk("ignore_latency", lat, 5);
        lit("ignore_s", 0, 1, 1, 2, 3);
        @(negedge clk);
        chk("ignore_idle_busy", int'(busy_w[0]), 0);
        chk("ignore_idle_done", int'(done_w[0]), 0);
        repeat (12) @(negedge clk);
        chk("ignore_done_count", dn_cnt[0] - d0, 1);

        // Reset in the middle of a conversion aborts it
        d0    = dn_cnt[0];
        a     = 8'h85;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lit($sformatf("abort%0d", i), i, 0, 0, 0, 0);
            chk($sformatf("abort_busy%0d", i), int'(busy_w[i]), 0);
        end
        repeat (12) @(negedge clk);
        chk("abort_done_count", dn_cnt[0] - d0, 0);
        convert("cf6", 8'hF6);
        lit("cf6_s", 0, 1, 0, 1, 0);
        lit("cf6_u", 1, 0, 2, 4, 6);
        @(negedge clk);

        // start held high: back-to-back conversions every 10 cycles
        d0    = dn_cnt[0];
        n0    = dn_cyc.size();
        a     = 8'h2A;
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_done_count", dn_cnt[0] - d0, 3);
        for (int k = 1; k < 3; k++) begin
            if (dn_cyc.size() > n0 + k) begin
                chk($sformatf("b2b_spacing%0d", k), dn_cyc[n0 + k] - dn_cyc[n0 + k - 1], 10);
            end
        end
        lit("b2b_s", 0, 0, 0, 4, 2);
        lit("b2b_u", 1, 0, 0, 4, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_bcd_converter.md
SIGNED_BCD_CONVERTER -- requirements
Module: signed_bcd_converter

Interface
REQ-001 The block SHALL have parameter SIGNED_IN, default 1: 1 = A is 8-bit two's complement (-128..127); 0 = A is unsigned (0..255).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request conversion; level sampled on clk edge in IDLE only.
REQ-005 The block SHALL have port A  input  8  value to convert; sampled on the same edge that accepts start.
REQ-006 The block SHALL have port sign  output  1  1 = captured value negative.
REQ-007 The block SHALL have ports hundreds, tens, ones  output  4 each  BCD digits of magnitude.
REQ-008 The block SHALL have port busy  output  1  high while in SHIFT.
REQ-009 The block SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-011 In IDLE with start=1 at edge N: capture A, compute sign and magnitude, clear 12-bit BCD shift register, load 4-bit shift counter with 8, go to SHIFT.
REQ-012 Sign SHALL be A[7] when SIGNED_IN=1, else 0; sign for A=0 SHALL be 0.
REQ-013 Magnitude SHALL be the two's-complement negation (invert, add 1) of A when sign=1, else A, as 8-bit unsigned.
REQ-014 A=0x80 with SIGNED_IN=1 SHALL yield magnitude 0x80 (unsigned 128), i.e. -128 is represented correctly.
REQ-015 Each SHIFT edge SHALL first add 3 to every BCD digit >= 5, then shift {bcd, magnitude} left by 1 and decrement the counter.
REQ-016 After the 8th shift (edge N+8) the FSM SHALL go to DONE and load hundreds/tens/ones/sign output registers in that same edge.
REQ-017 done SHALL be 1 for exactly the one cycle spent in DONE (between edges N+8 and N+9); DONE SHALL return to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly in SHIFT (the 8 cycles between edges N and N+8) and 0 in IDLE and DONE.
REQ-019 start while in SHIFT or DONE SHALL be ignored; no queuing. Changes on A outside the accepting edge SHALL have no effect.
REQ-020 Output digit/sign registers SHALL hold their last completed result until the next DONE entry; they SHALL NOT show intermediate shift values.
REQ-021 start held high continuously SHALL give back-to-back conversions: one every 10 cycles (accept, 8 shifts, DONE, then the next accept from IDLE).
REQ-022 Every digit output SHALL be in the range 0..9; hundreds SHALL be at most 2.

Reset
REQ-023 On a clk edge with rst_n=0: state=IDLE, counter=0, shift register=0, sign=0, hundreds=tens=ones=0, busy=0, done=0.
REQ-024 Reset SHALL take priority over all other activity, including in SHIFT or DONE; an aborted conversion SHALL produce no done pulse and SHALL leave outputs at 0.
REQ-025 start sampled in the same edge as rst_n=0 SHALL be discarded.

Verification
REQ-026 SIGNED_IN=1, A=0x85, start 1 cycle -> busy 8 cycles, done pulse at N+8; sign=1, digits 1,2,3.
REQ-027 SIGNED_IN=1, A=0x80 -> sign=1, digits 1,2,8; A=0x7F -> sign=0, digits 1,2,7; A=0x00 -> sign=0, digits 0,0,0.
REQ-028 SIGNED_IN=0, A=0xFF -> sign=0, digits 2,5,5; A=0x09 -> 0,0,9.
REQ-029 Start conversion of 0x85; at N+3 pulse start with A=0x01 -> only one done; result 1,2,3; IDLE reached at N+9.
REQ-030 Start conversion of 0x85; drive rst_n=0 at N+4 for 1 cycle -> busy=0 and all outputs 0 next cycle, no done; new start with A=0xF6 -> sign=1, digits 0,1,0.
REQ-031 start held high with A=0x2A for 30 cycles -> done pulses at 10-cycle spacing, each result sign=0, digits 0,4,2.
